// File: rtl/apb_slave_mem_pkg.sv
// Shared bridge package: APB slave FSM states, slave address regions,
// response encoding and a byte-lane merge helper.
package apb_slave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } apb_resp_t;

    localparam logic [31:0] SLV1_START = 32'h0001_F000;
    localparam logic [31:0] SLV1_END   = 32'h0001_F0FF;
    localparam logic [31:0] SLV2_START = 32'h0002_0000;
    localparam logic [31:0] SLV2_END   = 32'h0002_00FF;

    localparam int WAIT_CNT_W = 3;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between a master and apb_slave_mem.
interface apb_slave_mem_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [31:0]           pwdata_i;
    logic [3:0]            pstrb_i;
    logic [31:0]           prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, pstrb_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_slave_mem_wait_counter.sv
// Wait-state counter for the APB slave: load, decrement toward zero,
// and flags for "already zero" and "reaches zero on this decrement".
module apb_wait_counter
    import apb_slave_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  zero,
    output logic                  last
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == WAIT_CNT_W'(1));

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a small word-addressed memory, byte strobes, programmable
// wait states and SLVERR for out-of-range or misaligned addresses.
module apb_slave_mem
    import apb_slave_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(SLV1_START),
    parameter int                    DEPTH_WORDS = 64,
    parameter int                    WAIT_CYCLES = 1
)(
    input logic              clk,
    input logic              rst_n,
    apb_slave_mem_if.slave   bus
);

    localparam int                    IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0]   FIRST = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0]   LAST  = FIRST + (ADDR_WIDTH+1)'(4*DEPTH_WORDS)
                                              - (ADDR_WIDTH+1)'(1);

    apb_state_t            state_q, state_d;
    apb_resp_t             resp_q;
    logic                  write_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            strb_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic                  accept;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx_d;
    logic                  cnt_zero;
    logic                  cnt_last;
    logic                  unused_offset;

    // The extra top bit keeps the upper bound from wrapping near the top of the map.
    assign in_range = ({1'b0, bus.paddr_i} >= FIRST) && ({1'b0, bus.paddr_i} <= LAST)
                      && (bus.paddr_i[1:0] == 2'b00);
    assign offset        = bus.paddr_i - BASE_ADDR;
    assign idx_d         = offset[IDX_W+1:2];
    assign unused_offset = ^{offset[ADDR_WIDTH-1:IDX_W+2], offset[1:0]};
    assign accept        = (state_q == IDLE) && bus.psel_i && bus.penable_i;

    apb_wait_counter u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (WAIT_CNT_W'(WAIT_CYCLES)),
        .dec      (state_q == ACCESS),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // With no wait states ACCESS is skipped so pready still lands in the 2nd access cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.psel_i && bus.penable_i) begin
                    state_d = (WAIT_CYCLES == 0) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.psel_i || !bus.penable_i) begin
                    state_d = IDLE;
                end else if (cnt_last || cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q  <= RESP_OKAY;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            resp_q  <= in_range ? RESP_OKAY : RESP_SLVERR;
            write_q <= bus.pwrite_i;
            idx_q   <= idx_d;
            wdata_q <= bus.pwdata_i;
            strb_q  <= bus.pstrb_i;
        end
    end

    // Writes land on the edge that closes DONE, using only the captured transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if ((state_q == DONE) && write_q && (resp_q == RESP_OKAY)) begin
            mem[idx_q] <= merge_bytes(mem[idx_q], wdata_q, strb_q);
        end
    end

    always_comb begin
        bus.pready_o  = 1'b0;
        bus.pslverr_o = 1'b0;
        bus.prdata_o  = '0;
        if (state_q == DONE) begin
            bus.pready_o  = 1'b1;
            bus.pslverr_o = (resp_q == RESP_SLVERR);
            if (!write_q && (resp_q == RESP_OKAY)) begin
                bus.prdata_o = mem[idx_q];
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (1, 0 and 7 wait states) checked
// every cycle against a transfer-level model, plus directed literal checks.
module tb_apb_slave_mem;

    localparam logic [31:0] BASE = 32'h0001_F000;

    logic        clk;
    logic        rst_n;
    logic [2:0]  sel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    int tests = 0;
    int fails = 0;

    apb_slave_mem_if #(.ADDR_WIDTH(32)) bus0 ();
    apb_slave_mem_if #(.ADDR_WIDTH(32)) bus1 ();
    apb_slave_mem_if #(.ADDR_WIDTH(32)) bus2 ();

    assign bus0.psel_i = sel[0]; assign bus1.psel_i = sel[1]; assign bus2.psel_i = sel[2];
    assign bus0.penable_i = penable; assign bus1.penable_i = penable; assign bus2.penable_i = penable;
    assign bus0.pwrite_i = pwrite; assign bus1.pwrite_i = pwrite; assign bus2.pwrite_i = pwrite;
    assign bus0.paddr_i = paddr; assign bus1.paddr_i = paddr; assign bus2.paddr_i = paddr;
    assign bus0.pwdata_i = pwdata; assign bus1.pwdata_i = pwdata; assign bus2.pwdata_i = pwdata;
    assign bus0.pstrb_i = pstrb; assign bus1.pstrb_i = pstrb; assign bus2.pstrb_i = pstrb;

    logic        obs_ready [3];
    logic        obs_err   [3];
    logic [31:0] obs_data  [3];
    assign obs_ready[0] = bus0.pready_o; assign obs_err[0] = bus0.pslverr_o; assign obs_data[0] = bus0.prdata_o;
    assign obs_ready[1] = bus1.pready_o; assign obs_err[1] = bus1.pslverr_o; assign obs_data[1] = bus1.prdata_o;
    assign obs_ready[2] = bus2.pready_o; assign obs_err[2] = bus2.pslverr_o; assign obs_data[2] = bus2.prdata_o;

    apb_slave_mem #(.WAIT_CYCLES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    apb_slave_mem #(.WAIT_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    apb_slave_mem #(.WAIT_CYCLES(7)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Transfer-level model: an access completes after (wait states + 2) cycles of
    // psel&penable, using the bus values seen in the first of those cycles.
    int          wait_of [3] = '{1, 0, 7};
    int          acc     [3] = '{0, 0, 0};
    logic [31:0] cap_addr [3];
    logic [31:0] cap_data [3];
    logic [3:0]  cap_strb [3];
    logic        cap_wr   [3];
    logic [31:0] mdl_mem  [3][64];

    function automatic logic modelInRange(input logic [31:0] addr);
        return (addr >= BASE) && ((addr - BASE) < 32'd256) && (addr[1:0] == 2'b00);
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic        exp_ready;
            logic        exp_err;
            logic [31:0] exp_data;
            int          widx;
            exp_ready = 1'b0;
            exp_err   = 1'b0;
            exp_data  = 32'h0;
            if (!rst_n) begin
                for (int i = 0; i < 64; i++) mdl_mem[k][i] = 32'h0;
                acc[k] = 0;
            end else if (sel[k] && penable) begin
                acc[k]++;
                if (acc[k] == 1) begin
                    cap_addr[k] = paddr;
                    cap_data[k] = pwdata;
                    cap_strb[k] = pstrb;
                    cap_wr[k]   = pwrite;
                end
                if (acc[k] == wait_of[k] + 2) begin
                    exp_ready = 1'b1;
                    exp_err   = !modelInRange(cap_addr[k]);
                    widx      = int'((cap_addr[k] - BASE) / 4) % 64;
                    if (!cap_wr[k] && !exp_err) exp_data = mdl_mem[k][widx];
                    if (cap_wr[k] && !exp_err) begin
                        for (int b = 0; b < 4; b++) begin
                            if (cap_strb[k][b]) mdl_mem[k][widx][8*b +: 8] = cap_data[k][8*b +: 8];
                        end
                    end
                    acc[k] = 0;
                end
            end else begin
                acc[k] = 0;
            end
            checkOutput($sformatf("dut%0d_pready", k), 32'(obs_ready[k]), 32'(exp_ready));
            checkOutput($sformatf("dut%0d_pslverr", k), 32'(obs_err[k]), 32'(exp_err));
            checkOutput($sformatf("dut%0d_prdata", k), obs_data[k], exp_data);
        end
    end

    // mode 0: normal transfer; 1: drop psel/penable after abort_at cycles;
    // 2: assert reset after abort_at cycles. Bus values are scrambled once the
    // transfer has been accepted, which must not affect the result.
    task automatic applyStimulus(input int k, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input int mode, input int abort_at,
                                 output int lat, output logic [31:0] rdata, output logic err);
        logic got;
        got = 1'b0; lat = 0; rdata = 32'h0; err = 1'b0;
        @(posedge clk); #1;
        sel = 3'b000; sel[k] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (obs_ready[k]) begin
                got = 1'b1; lat = c; rdata = obs_data[k]; err = obs_err[k];
                break;
            end
            if (mode != 0 && c == abort_at) begin
                @(posedge clk); #1;
                sel = 3'b000; penable = 1'b0;
                if (mode == 2) begin
                    rst_n = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 rst_n = 1'b1;
                end
                break;
            end
            if (c == 1) begin
                @(posedge clk); #1;
                paddr = addr ^ 32'h40; pwdata = ~data; pstrb = ~strb;
            end
        end
        checkOutput($sformatf("dut%0d_completed", k), 32'(got), (mode == 0) ? 32'd1 : 32'd0);
        if (mode == 0) begin
            @(posedge clk); #1;
            sel = 3'b000; penable = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;
        sel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // SETUP only: nothing may happen.
        sel = 3'b001; paddr = 32'h0001_F004; pwrite = 1'b1; pwdata = 32'h1234_5678; pstrb = 4'hF;
        repeat (3) @(posedge clk);
        #1 sel = 3'b000;

        applyStimulus(0, 1'b1, 32'h0001_F004, 32'hDEAD_BEEF, 4'hF, 0, 0, lat, rd, err);
        checkOutput("wr_beef_latency", 32'(lat), 32'd3);
        checkOutput("wr_beef_err", 32'(err), 32'd0);
        applyStimulus(0, 1'b0, 32'h0001_F004, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_beef_data", rd, 32'hDEAD_BEEF);
        checkOutput("rd_beef_latency", 32'(lat), 32'd3);

        applyStimulus(0, 1'b1, 32'h0001_F008, 32'hFFFF_FFFF, 4'hF, 0, 0, lat, rd, err);
        applyStimulus(0, 1'b1, 32'h0001_F008, 32'h1122_3344, 4'b0101, 0, 0, lat, rd, err);
        applyStimulus(0, 1'b0, 32'h0001_F008, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_strobe_merge", rd, 32'hFF22_FF44);

        applyStimulus(0, 1'b1, 32'h0001_F008, 32'h0000_0000, 4'b0000, 0, 0, lat, rd, err);
        checkOutput("wr_nostrb_err", 32'(err), 32'd0);
        applyStimulus(0, 1'b0, 32'h0001_F008, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_after_nostrb", rd, 32'hFF22_FF44);

        applyStimulus(0, 1'b0, 32'h0002_0000, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_oor_err", 32'(err), 32'd1);
        checkOutput("rd_oor_data", rd, 32'h0);
        applyStimulus(0, 1'b0, 32'h0001_F002, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_misalign_err", 32'(err), 32'd1);
        checkOutput("rd_misalign_data", rd, 32'h0);
        applyStimulus(0, 1'b1, 32'h0001_F006, 32'hAAAA_AAAA, 4'hF, 0, 0, lat, rd, err);
        checkOutput("wr_misalign_err", 32'(err), 32'd1);
        applyStimulus(0, 1'b0, 32'h0001_F004, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_beef_unchanged", rd, 32'hDEAD_BEEF);

        applyStimulus(0, 1'b1, 32'h0001_F0FC, 32'hCAFE_F00D, 4'hF, 0, 0, lat, rd, err);
        checkOutput("wr_last_err", 32'(err), 32'd0);
        applyStimulus(0, 1'b0, 32'h0001_F0FC, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_last_data", rd, 32'hCAFE_F00D);
        applyStimulus(0, 1'b1, 32'h0001_F100, 32'h1234_5678, 4'hF, 0, 0, lat, rd, err);
        checkOutput("wr_past_end_err", 32'(err), 32'd1);
        applyStimulus(0, 1'b0, 32'h0001_F000, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_word0_untouched", rd, 32'h0);

        applyStimulus(1, 1'b1, 32'h0001_F020, 32'h0BAD_F00D, 4'hF, 0, 0, lat, rd, err);
        checkOutput("w0_wr_latency", 32'(lat), 32'd2);
        applyStimulus(1, 1'b0, 32'h0001_F020, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("w0_rd_data", rd, 32'h0BAD_F00D);
        checkOutput("w0_rd_latency", 32'(lat), 32'd2);

        applyStimulus(2, 1'b1, 32'h0001_F010, 32'h5555_AAAA, 4'hF, 0, 0, lat, rd, err);
        checkOutput("w7_wr_latency", 32'(lat), 32'd9);
        applyStimulus(2, 1'b1, 32'h0001_F010, 32'hFFFF_FFFF, 4'hF, 1, 3, lat, rd, err);
        applyStimulus(2, 1'b0, 32'h0001_F010, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("w7_rd_after_abort", rd, 32'h5555_AAAA);
        checkOutput("w7_rd_latency", 32'(lat), 32'd9);

        applyStimulus(2, 1'b1, 32'h0001_F014, 32'h7777_7777, 4'hF, 2, 4, lat, rd, err);
        applyStimulus(0, 1'b0, 32'h0001_F004, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_after_reset_dut0", rd, 32'h0);
        applyStimulus(2, 1'b0, 32'h0001_F014, 32'h0, 4'h0, 0, 0, lat, rd, err);
        checkOutput("rd_after_reset_dut2", rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
